// File: rtl/mem_cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory command controller:
//   - default address/data widths and command FIFO depth
//   - controller state encoding (INIT zeroing pass, RUN servicing requests)
//   - packed command record {wr_rdn, addr, data} at the default widths
//   - helper returning the packed command width for arbitrary widths
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_AW         = 4;
  localparam int MEM_DW         = 8;
  localparam int MEM_FIFO_DEPTH = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic              wr_rdn;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
  } mem_cmd_t;

  // Width of a packed {wr_rdn, addr, data} command for the given field widths.
  function automatic int mem_cmd_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// -----------------------------------------------------------------------------
// mem_cmd_fifo
// Synchronous in-order command FIFO.
// Ports:
//   clk      in   clock, all logic on posedge
//   rst      in   synchronous active-high reset; empties the FIFO
//   i_push   in   write i_din at this edge (ignored when full)
//   i_din    in   W-bit command
//   i_pop    in   retire the head entry at this edge (ignored when empty)
//   o_head   out  oldest entry (valid while !o_empty)
//   o_full   out  no free entries
//   o_empty  out  no stored entries
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
// -----------------------------------------------------------------------------
module mem_cmd_fifo
  import mem_pkg::*;
#(
  parameter int W     = mem_cmd_w(MEM_AW, MEM_DW),
  parameter int DEPTH = MEM_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  r_wr_ptr;
  logic [PW:0]  r_rd_ptr;
  logic [W-1:0] r_buf [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // Full: same slot index, opposite lap. Empty: identical pointers.
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_head  = r_buf[r_rd_ptr[PW-1:0]];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  // Storage holds data only; occupancy is defined by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_buf[r_wr_ptr[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mem_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// mem_cmd_ctrl
// Memory-side consumer of the request bus. Requests are queued in an in-order
// command FIFO and executed one per cycle against a (2**AW) x DW register
// array. Read results leave through a stallable output register with a
// valid/ready handshake. After reset an INIT pass zeroes the whole array.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   req_valid  in   request present on wr_rdn/addr/in_data
//   req_ready  out  request accepted when req_valid && req_ready
//   wr_rdn     in   1 = write, 0 = read
//   addr       in   AW-bit target address
//   in_data    in   DW-bit write data
//   out_data   out  last read result
//   rd_valid   out  out_data holds an unconsumed result
//   rd_ready   in   consumer takes the result when rd_valid && rd_ready
//   init_done  out  INIT pass finished
// -----------------------------------------------------------------------------
module mem_cmd_ctrl
  import mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int FIFO_DEPTH = MEM_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          wr_rdn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          init_done
);

  localparam int CW = mem_cmd_w(AW, DW);
  localparam int NW = 2**AW;

  typedef struct packed {
    logic          wr_rdn;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  mem_state_e    r_state;
  logic [AW-1:0] r_init_cnt;
  logic          r_init_done;
  logic          r_rd_valid;
  logic [DW-1:0] r_out_data;
  logic [DW-1:0] r_mem [NW];

  cmd_t          w_push_cmd;
  cmd_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_pop_wr;
  logic          w_pop_rd;
  logic          w_run;

  assign w_run     = (r_state == RUN);

  // Ready comes from registered state only, never from req_valid.
  assign req_ready = w_run && !w_full;
  assign w_push    = req_valid && req_ready;

  assign w_push_cmd = {wr_rdn, addr, in_data};

  // Writes always retire; reads retire only when the output slot is free or
  // being drained this same edge. A stalled read blocks everything behind it.
  assign w_pop_wr = w_run && !w_empty && w_head.wr_rdn;
  assign w_pop_rd = w_run && !w_empty && !w_head.wr_rdn &&
                    (!r_rd_valid || rd_ready);
  assign w_pop    = w_pop_wr || w_pop_rd;

  mem_cmd_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Controller FSM: INIT walks every address once, then RUN until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt + AW'(1);
          if (r_init_cnt == '1) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end
        end
        RUN: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

  // Register array: zeroing pass owns the write port during INIT; the FIFO
  // is always empty then, so the two writers never collide.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_pop_wr) begin
      r_mem[w_head.addr] <= w_head.data;
    end
  end

  // Output slot: a read pop refills it (keeping rd_valid high across
  // back-to-back reads); otherwise a completed handshake empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_out_data <= '0;
    end else if (w_pop_rd) begin
      r_rd_valid <= 1'b1;
      r_out_data <= r_mem[w_head.addr];
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_valid  = r_rd_valid;
  assign out_data  = r_out_data;
  assign init_done = r_init_done;

endmodule
